multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Parametrised multi-cycle instruction sequencer for the MINI_CPU: drives the
//  FETCH/DECODE/EXECUTE/WRITEBACK phase enables and owns the PC. Successor to
//  the fixed 5-state controller. Adds variable-latency fetch and execute
//  handshakes, optional writeback skip, branch PC load, run/idle and halt.
//  Sits between the instruction memory, the decoder, the ALU and the register file.
// PARAMETERS
//  PC_W      8   PC width in bits; PC arithmetic wraps modulo 2**PC_W
//  RESET_PC  0   PC value loaded at reset
//  PC_INC    1   PC increment per sequential instruction
//  CNT_W     16  width of the perf counters (used only with MC_PERF_CNT_EN)
// PORTS
//  clk            in   1      clock; all logic on posedge
//  reset_n        in   1      synchronous active-low reset
//  run            in   1      1 = sequence instructions; 0 = drop to IDLE after retire
//  halt_req       in   1      request halt; sticky until reset
//  imem_ack       in   1      instruction memory: fetch data valid this cycle
//  exec_done      in   1      ALU: execute phase finished this cycle
//  wb_skip        in   1      decoder: instruction has no writeback (sampled in DECODE)
//  branch_taken   in   1      ALU: load PC from branch_target (sampled with exec_done)
//  branch_target  in   PC_W   branch destination
//  pc             out  PC_W   current PC
//  imem_req       out  1      fetch request, high for the whole FETCH state
//  fetch_en       out  1      high in FETCH
//  decode_en      out  1      high in DECODE
//  exec_en        out  1      high in EXECUTE
//  wb_en          out  1      high in WRITEBACK
//  retire         out  1      one-cycle pulse in NEXT
//  busy           out  1      state is not IDLE and not HALT
//  halted         out  1      state is HALT
//  cycle_cnt      out  CNT_W  active-cycle counter (0 without the macro)
//  instr_cnt      out  CNT_W  retired-instruction counter (0 without the macro)
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge) wins over everything: state=IDLE, pc=RESET_PC,
//    halt_pend=0, wb_skip_q=0, branch_q=0, counters=0. All outputs are Moore
//    decodes of state, so every enable/retire/busy/halted output is 0 in reset.
//  - IDLE: if halt_req -> HALT; else if run -> FETCH; else stay.
//  - FETCH: imem_req=fetch_en=1; stay until imem_ack=1, then -> DECODE.
//    Minimum fetch latency is 1 cycle.
//  - DECODE: one cycle; register wb_skip_q<=wb_skip; -> EXECUTE.
//  - EXECUTE: exec_en=1 until exec_done=1. In that same cycle capture
//    branch_q<=branch_taken and tgt_q<=branch_target; then -> NEXT if
//    wb_skip_q, else -> WRITEBACK.
//  - WRITEBACK: wb_en=1 for exactly one cycle; -> NEXT.
//  - NEXT: retire=1; pc <= branch_q ? tgt_q : pc+PC_INC (wraps, e.g. 8'hFF+1=0).
//    Then: halt_pend -> HALT; else run -> FETCH; else -> IDLE.
//  - HALT: halted=1; absorbing; left only by reset. pc holds.
//  - halt_req seen in any non-IDLE state sets halt_pend. The in-flight
//    instruction always completes and retires before HALT.
//  - run deasserted mid-instruction does not abort; it is only checked in IDLE/NEXT.
//  - imem_ack outside FETCH and exec_done outside EXECUTE are ignored.
//  - Fastest instruction: 5 cycles (F,D,E,WB,N); with wb_skip: 4 cycles.
//  - Reset asserted mid-instruction: the instruction is abandoned, with no
//    retire and no PC update.
//  - Unused state encodings recover to IDLE.
// CONFIGURATION
//  MC_PERF_CNT_EN defined: cycle_cnt +1 every cycle busy=1; instr_cnt +1 on
//    every retire. Both saturate at all-ones and clear only on reset.
//  MC_PERF_CNT_EN undefined: no counter flops; cycle_cnt and instr_cnt are tied to 0.
// TESTING
//  1. reset_n=0, then run=1 with imem_ack and exec_done tied to 1 -> pc=0,
//     enables follow F,D,E,WB,N; retire every 5 cycles; pc=1,2,3.
//  2. imem_ack delayed 3 cycles and exec_done delayed 2 -> FETCH held 4 cycles,
//     EXECUTE held 3 cycles; one retire; pc +1.
//  3. wb_skip=1 in DECODE -> WRITEBACK skipped (wb_en never 1); retire 4 cycles
//     after FETCH entry.
//  4. branch_taken=1, branch_target=8'h40 with exec_done -> pc=8'h40 after NEXT.
//     Separately, pc=8'hFF sequential -> pc=8'h00.
//  5. halt_req pulsed during EXECUTE -> instruction retires, halted=1, pc frozen.
//     Pulling run low in IDLE does not leave HALT; only reset_n=0 does.
//  6. With MC_PERF_CNT_EN and CNT_W=4 -> 3 instructions give instr_cnt=3.
//     cycle_cnt saturates at 4'hF. Reset mid-EXECUTE clears both and gives no retire.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK phase enables and PC ownership.
// Optional perf counters are compiled in with `define MC_PERF_CNT_EN; otherwise cycle_cnt/instr_cnt read 0.
module multicycle_ctrl #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int PC_INC   = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             halt_req,
  input  logic             imem_ack,
  input  logic             exec_done,
  input  logic             wb_skip,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             imem_req,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic             retire,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // Handshake: imem_ack is honoured only while in FETCH and exec_done only while
  // in EXECUTE; both are single-cycle qualifiers, never latched outside those states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_NEXT   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            halt_pend_q, halt_pend_d;
  logic            wb_skip_q, wb_skip_d;
  logic            branch_q, branch_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_W'(RESET_PC);
      tgt_q       <= '0;
      halt_pend_q <= 1'b0;
      wb_skip_q   <= 1'b0;
      branch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      halt_pend_q <= halt_pend_d;
      wb_skip_q   <= wb_skip_d;
      branch_q    <= branch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    wb_skip_d   = wb_skip_q;
    branch_d    = branch_q;
    // A halt request during an instruction is remembered until it retires.
    halt_pend_d = halt_pend_q | (halt_req && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (halt_req)  state_d = S_HALT;
        else if (run)  state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        wb_skip_d = wb_skip;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          branch_d = branch_taken;
          tgt_d    = branch_target;
          state_d  = wb_skip_q ? S_NEXT : S_WB;
        end
      end
      S_WB: state_d = S_NEXT;
      S_NEXT: begin
        pc_d = branch_q ? tgt_q : pc_q + PC_W'(PC_INC);
        if (halt_pend_q) state_d = S_HALT;
        else if (run)    state_d = S_FETCH;
        else             state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    wb_en     = 1'b0;
    retire    = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH:  begin imem_req = 1'b1; fetch_en = 1'b1; busy = 1'b1; end
      S_DECODE: begin decode_en = 1'b1; busy = 1'b1; end
      S_EXEC:   begin exec_en = 1'b1; busy = 1'b1; end
      S_WB:     begin wb_en = 1'b1; busy = 1'b1; end
      S_NEXT:   begin retire = 1'b1; busy = 1'b1; end
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end

  assign pc = pc_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (busy && (cycle_cnt_q != '1))   cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (retire && (instr_cnt_q != '1)) instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instruction latency/branch vectors plus hand-written
// halt, run-drop, reset-abort and perf-counter sequences; retired PCs go through a scoreboard.
module tb_multicycle_ctrl;
`ifdef MC_PERF_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic                clk = 1'b0;
  logic                reset_n, run, halt_req, imem_ack, exec_done, wb_skip, branch_taken;
  logic [7:0]          branch_target, pc;
  logic                imem_req, fetch_en, decode_en, exec_en, wb_en, retire, busy, halted;
  logic [TB_CNT_W-1:0] cycle_cnt, instr_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       retire_d = 1'b0;
  logic [7:0] model_pc;

  typedef struct {
    int         fetch_wait;
    int         exec_wait;
    bit         skip;
    bit         br;
    logic [7:0] tgt;
    logic [7:0] exp_pc;
    int         exp_lat;
  } vec_t;
  vec_t tbl[10];

  multicycle_ctrl #(.PC_W(8), .RESET_PC(0), .PC_INC(1), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .halt_req(halt_req),
    .imem_ack(imem_ack), .exec_done(exec_done), .wb_skip(wb_skip),
    .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc),
    .imem_req(imem_req), .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .wb_en(wb_en), .retire(retire), .busy(busy),
    .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    wb_skip = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    model_pc = 8'h00;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [7:0] exp_pc);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_enables"}, {imem_req, fetch_en, decode_en, exec_en, wb_en, retire}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Driver: plays one instruction, starting at a negedge, ending at the NEXT-state negedge.
  task automatic do_instr(input vec_t v, input bit halt_in_exec);
    int n;
    int cyc;
    n = 0;
    while (!fetch_en && n < 40) begin @(negedge clk); n++; end
    chk("fetch_entry", fetch_en, 1);
    exp_q.push_back(v.exp_pc);
    cyc = 1;
    for (int k = 0; k < v.fetch_wait; k++) begin
      chk("fetch_hold", {imem_req, fetch_en, busy}, 3'b111);
      imem_ack = 1'b0; exec_done = 1'($urandom_range(0, 1));
      @(negedge clk); cyc++;
    end
    chk("fetch_last", {imem_req, fetch_en}, 2'b11);
    imem_ack = 1'b1; exec_done = 1'($urandom_range(0, 1));
    @(negedge clk); cyc++;
    chk("decode_en", {fetch_en, decode_en}, 2'b01);
    imem_ack = 1'($urandom_range(0, 1)); exec_done = 1'b0; wb_skip = v.skip;
    @(negedge clk); cyc++;
    wb_skip = 1'($urandom_range(0, 1));
    if (halt_in_exec) halt_req = 1'b1;
    for (int k = 0; k < v.exec_wait; k++) begin
      chk("exec_hold", {exec_en, busy}, 2'b11);
      exec_done = 1'b0; branch_taken = 1'($urandom_range(0, 1));
      branch_target = 8'($urandom_range(0, 255));
      @(negedge clk); cyc++;
      halt_req = 1'b0;
    end
    chk("exec_last", exec_en, 1);
    exec_done = 1'b1; branch_taken = v.br; branch_target = v.tgt;
    @(negedge clk); cyc++;
    halt_req = 1'b0; exec_done = 1'b0;
    branch_taken = 1'($urandom_range(0, 1)); branch_target = 8'($urandom_range(0, 255));
    if (!v.skip) begin
      chk("wb_en", {exec_en, wb_en, retire}, 3'b010);
      @(negedge clk); cyc++;
    end
    chk("retire", {wb_en, retire}, 2'b01);
    chk("latency", cyc, v.exp_lat);
    imem_ack = 1'b0;
  endtask

  // Scoreboard: compare PC on the cycle after each retire pulse.
  always @(negedge clk) begin
    if (reset_n && retire_d) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_retire: pc %0h with empty queue at %0t", pc, $time);
      end else begin
        chk("pc_after_retire", pc, exp_q.pop_front());
      end
    end
    retire_d = reset_n && retire;
  end

  initial begin
    vec_t hv;
    tbl[0] = '{0, 0, 1'b0, 1'b0, 8'h00, 8'h01, 5};
    tbl[1] = '{0, 0, 1'b0, 1'b0, 8'h00, 8'h02, 5};
    tbl[2] = '{0, 0, 1'b0, 1'b0, 8'h00, 8'h03, 5};
    tbl[3] = '{3, 2, 1'b0, 1'b0, 8'h00, 8'h04, 10};
    tbl[4] = '{0, 0, 1'b1, 1'b0, 8'h00, 8'h05, 4};
    tbl[5] = '{1, 1, 1'b1, 1'b1, 8'h40, 8'h40, 6};
    tbl[6] = '{0, 0, 1'b0, 1'b1, 8'hFE, 8'hFE, 5};
    tbl[7] = '{0, 0, 1'b1, 1'b0, 8'h00, 8'hFF, 4};
    tbl[8] = '{0, 0, 1'b0, 1'b0, 8'h00, 8'h00, 5};
    tbl[9] = '{2, 0, 1'b0, 1'b1, 8'h10, 8'h10, 7};

    do_reset();
    chk_idle_outputs("reset", 8'h00);
    chk("reset_halted", halted, 0);
    chk("reset_cnt", {cycle_cnt, instr_cnt}, 0);
    run = 1'b1;
    for (int i = 0; i < 10; i++) do_instr(tbl[i], 1'b0);

    // run dropped mid-instruction: it completes, then the sequencer idles
    @(negedge clk);
    run = 1'b0;
    hv = '{0, 1, 1'b0, 1'b0, 8'h00, 8'h11, 6};
    do_instr(hv, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk_idle_outputs("idle_hold", 8'h11);
    end

    // halt during EXECUTE: retire first, then frozen in HALT
    run = 1'b1;
    hv = '{0, 2, 1'b0, 1'b0, 8'h00, 8'h12, 7};
    do_instr(hv, 1'b1);
    @(negedge clk);
    chk("halt_entered", {halted, busy}, 2'b10);
    run = 1'b0; imem_ack = 1'b1; exec_done = 1'b1;
    repeat (5) @(negedge clk);
    chk("halt_absorbing", halted, 1);
    chk_idle_outputs("halt_frozen", 8'h12);
    do_reset();
    chk("halt_cleared", halted, 0);
    chk_idle_outputs("reset2", 8'h00);

    // halt request from IDLE goes straight to HALT
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    chk("idle_halt", halted, 1);
    do_reset();

    // reset mid-EXECUTE abandons the instruction
    run = 1'b1;
    @(negedge clk);
    chk("abort_fetch", fetch_en, 1);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("abort_exec", exec_en, 1);
    reset_n = 1'b0; run = 1'b0; exec_done = 1'b1;
    @(negedge clk);
    chk("abort_retire", retire, 0);
    chk_idle_outputs("abort", 8'h00);
    chk("abort_cnt", {cycle_cnt, instr_cnt}, 0);
    reset_n = 1'b1; exec_done = 1'b0;
    @(negedge clk);
    chk_idle_outputs("abort_after", 8'h00);

`ifdef MC_PERF_CNT_EN
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 3; i++) do_instr(tbl[i], 1'b0);
    @(negedge clk);
    chk("instr_cnt_3", instr_cnt, 3);
    chk("cycle_cnt_15", cycle_cnt, 4'hF);
    model_pc = 8'h03;
    for (int i = 0; i < 14; i++) begin
      model_pc = model_pc + 8'h01;
      hv = '{0, 0, 1'b0, 1'b0, 8'h00, model_pc, 5};
      do_instr(hv, 1'b0);
    end
    run = 1'b0;
    @(negedge clk);
    chk("cycle_cnt_sat", cycle_cnt, 4'hF);
    chk("instr_cnt_sat", instr_cnt, 4'hF);
`else
    chk("cnt_tied_zero", {cycle_cnt, instr_cnt}, 0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
